// File: rtl/mips_mem_pkg.sv
// Shared definitions for the byte-addressed MIPS data memory:
// access-size encodings, FSM states and the request fault predicate.
package mips_mem_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } memState_t;

    // A faulting request gets a response but never touches the array
    function automatic logic accessFault(
        input logic [DATA_WIDTH-1:0] addr,
        input logic [1:0]            size,
        input logic                  rd,
        input logic                  wr,
        input int unsigned           addrWidth
    );
        logic misaligned;
        logic outOfRange;
        misaligned = ((size == SIZE_HALF) && addr[0]) ||
                     ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
        outOfRange = (addrWidth < DATA_WIDTH) && ((addr >> addrWidth) != 32'd0);
        return misaligned || outOfRange || (size == SIZE_ILLEGAL) || (rd && wr);
    endfunction

endpackage

// File: rtl/mips_mem_lane_align.sv
// Byte-lane steering: store byte enables / shifted data, and load lane
// extraction with sign or zero extension. Purely combinational.
module mips_mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]            ByteOffset,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [DATA_WIDTH-1:0] ReadWord,
    output logic [3:0]            ByteEnable_c,
    output logic [DATA_WIDTH-1:0] WriteLanes_c,
    output logic [DATA_WIDTH-1:0] LoadData_c
);

    logic [DATA_WIDTH-1:0] laneWord;

    always_comb begin
        ByteEnable_c = 4'b0000;
        WriteLanes_c = WriteData;
        LoadData_c   = '0;
        laneWord     = ReadWord >> {ByteOffset, 3'b000};
        case (Size)
            SIZE_BYTE: begin
                ByteEnable_c = 4'b0001 << ByteOffset;
                WriteLanes_c = WriteData << {ByteOffset, 3'b000};
                LoadData_c   = Unsigned ? {24'd0, laneWord[7:0]}
                                        : {{24{laneWord[7]}}, laneWord[7:0]};
            end
            SIZE_HALF: begin
                ByteEnable_c = 4'b0011 << ByteOffset;
                WriteLanes_c = WriteData << {ByteOffset, 3'b000};
                LoadData_c   = Unsigned ? {16'd0, laneWord[15:0]}
                                        : {{16{laneWord[15]}}, laneWord[15:0]};
            end
            SIZE_WORD: begin
                ByteEnable_c = 4'b1111;
                WriteLanes_c = WriteData;
                LoadData_c   = ReadWord;
            end
            default: begin
                ByteEnable_c = 4'b0000;
                LoadData_c   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mips_byte_data_memory.sv
// MEM-stage data memory: byte/half/word little-endian access, fault
// flagging, hardware clear after reset and a configurable read pipeline.
module mips_byte_data_memory
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            Size,
    input  logic                  Unsigned,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  RespValid,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Fault
);

    localparam int unsigned WORD_BITS = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH     = 1 << WORD_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    memState_t             state;
    memState_t             stateNext;
    logic [WORD_BITS-1:0]  clearAddr;
    logic [WORD_BITS-1:0]  clearAddrNext;
    logic                  clearWrite;

    logic                  accept;
    logic                  reqFault;
    logic                  memWriteEn;
    logic                  respStart;
    logic [WORD_BITS-1:0]  wordIdx;
    logic [DATA_WIDTH-1:0] readWord;
    logic [3:0]            byteEnable;
    logic [DATA_WIDTH-1:0] writeLanes;
    logic [DATA_WIDTH-1:0] loadData;

    logic                  pipeValid [READ_LATENCY];
    logic                  pipeFault [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipeData  [READ_LATENCY];

    assign accept     = ReqValid & ReqReady;
    assign reqFault   = accessFault(Address, Size, MemRead, MemWrite, ADDR_WIDTH);
    assign memWriteEn = accept & MemWrite & ~reqFault;
    assign respStart  = accept & (MemRead | MemWrite);
    assign wordIdx    = Address[ADDR_WIDTH-1:2];
    assign readWord   = mem[wordIdx];

    mips_mem_lane_align u_lane_align (
        .ByteOffset   (Address[1:0]),
        .Size         (Size),
        .Unsigned     (Unsigned),
        .WriteData    (WriteData),
        .ReadWord     (readWord),
        .ByteEnable_c (byteEnable),
        .WriteLanes_c (writeLanes),
        .LoadData_c   (loadData)
    );

    // Clear sweep: one word per cycle, then open for requests
    always_comb begin
        stateNext     = state;
        clearAddrNext = clearAddr;
        clearWrite    = 1'b0;
        case (state)
            CLEAR: begin
                clearWrite    = 1'b1;
                clearAddrNext = clearAddr + WORD_BITS'(1);
                if (clearAddr == WORD_BITS'(DEPTH - 1)) begin
                    stateNext = READY;
                end
            end
            READY: begin
                stateNext = READY;
            end
            default: begin
                stateNext = READY;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= CLEAR_ON_RESET ? CLEAR : READY;
            clearAddr <= '0;
            ReqReady  <= ~CLEAR_ON_RESET;
        end else begin
            state     <= stateNext;
            clearAddr <= clearAddrNext;
            ReqReady  <= (stateNext == READY);
        end
    end

    // Array has no reset; the clear sweep owns initialisation
    always_ff @(posedge Clk) begin
        if (clearWrite) begin
            mem[clearAddr] <= '0;
        end else if (memWriteEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEnable[b]) begin
                    mem[wordIdx][8*b +: 8] <= writeLanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipeValid[i] <= 1'b0;
                pipeFault[i] <= 1'b0;
                pipeData[i]  <= '0;
            end
        end else begin
            pipeValid[0] <= respStart;
            pipeFault[0] <= respStart & reqFault;
            pipeData[0]  <= (respStart & MemRead & ~reqFault) ? loadData : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeFault[i] <= pipeFault[i-1];
                pipeData[i]  <= pipeData[i-1];
            end
        end
    end

    assign RespValid = pipeValid[READ_LATENCY-1];
    assign Fault     = pipeFault[READ_LATENCY-1];
    assign ReadData  = pipeData[READ_LATENCY-1];

endmodule

// File: tb/tb_mips_byte_data_memory.sv
// Scoreboard bench for mips_byte_data_memory: byte-array reference model,
// directed and random requests, monitor pops expectations on RespValid.
module tb_mips_byte_data_memory;
    import mips_mem_pkg::*;

    localparam int unsigned AW        = 6;
    localparam int unsigned LAT       = 3;
    localparam int unsigned MEM_BYTES = 1 << AW;
    localparam int unsigned DEPTH     = MEM_BYTES / 4;

    logic        Clk;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        RespValid;
    logic [31:0] ReadData;
    logic        Fault;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] refMem [MEM_BYTES];
    int         checks = 0;
    int         passes = 0;
    int         cyc    = 0;

    mips_byte_data_memory #(
        .ADDR_WIDTH     (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .Address   (Address),
        .WriteData (WriteData),
        .RespValid (RespValid),
        .ReadData  (ReadData),
        .Fault     (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: flat little-endian byte array, rules applied directly
    function automatic bit modelFault(input logic [31:0] a, input logic [1:0] sz,
                                      input bit rd, input bit wr);
        return (a >= 32'(MEM_BYTES)) || (sz == 2'd3) ||
               (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (rd && wr);
    endfunction

    function automatic int nBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < int'(MEM_BYTES); i++) refMem[i] = 8'h00;
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        bit          f;
        int          n;
        logic [31:0] v;
        @(negedge Clk);
        check("req_ready_at_issue", 32'(ReqReady), 32'd1);
        ReqValid  = 1'b1;
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        Unsigned  = uns;
        Address   = a;
        WriteData = wd;
        f = modelFault(a, sz, rd, wr);
        n = nBytes(sz);
        if (rd || wr) begin
            v = 32'd0;
            if (!f && rd) begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[int'(a) + i];
                if (!uns && n < 4 && v[8*n-1])
                    for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            end
            if (!f && wr)
                for (int i = 0; i < n; i++) refMem[int'(a) + i] = wd[8*i +: 8];
            e.fault = f;
            e.data  = v;
            e.cyc   = cyc + int'(LAT);
            expQ.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge Clk);
        ReqValid = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (expQ.size() != 0 && t < 50) begin
            @(negedge Clk);
            t++;
        end
        check("drain_outstanding", 32'(expQ.size()), 32'd0);
    endtask

    task automatic releaseAndMeasure(output int lows, output int resp);
        lows = 0;
        resp = 0;
        @(negedge Clk);
        Reset = 1'b0;
        while (!ReqReady && lows < 200) begin
            lows++;
            if (RespValid) resp++;
            @(negedge Clk);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation
    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!Reset && RespValid) begin
            if (expQ.size() == 0) begin
                checks++;
                $display("FAIL unexpected_resp: RespValid=1 Data=%h Fault=%b, no request outstanding",
                         ReadData, Fault);
            end else begin
                e = expQ.pop_front();
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
                check("resp_fault", 32'(Fault), 32'(e.fault));
                check("resp_data", ReadData, e.data);
            end
        end
    end

    initial begin
        int          lows;
        int          resp;
        bit          rd;
        bit          wr;
        logic [1:0]  sz;
        logic [31:0] a;
        int          sel;

        Reset = 1'b1; ReqValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Size = 2'b00; Unsigned = 1'b0; Address = '0; WriteData = '0;
        repeat (3) @(negedge Clk);
        check("reset_req_ready", 32'(ReqReady), 32'd0);
        check("reset_resp_valid", 32'(RespValid), 32'd0);
        check("reset_read_data", ReadData, 32'd0);
        check("reset_fault", 32'(Fault), 32'd0);

        releaseAndMeasure(lows, resp);
        check("clear_cycles", 32'(lows), 32'(DEPTH));
        check("clear_no_resp", 32'(resp), 32'd0);
        clearModel();

        for (int i = 0; i < int'(MEM_BYTES); i += 4) issue(1, 0, SIZE_WORD, 0, 32'(i), 32'd0);

        issue(0, 1, SIZE_WORD, 0, 32'h10, 32'h11223344);
        for (int i = 0; i < 4; i++) issue(1, 0, SIZE_BYTE, 1, 32'h10 + 32'(i), 32'd0);
        issue(1, 0, SIZE_HALF, 0, 32'h12, 32'd0);
        issue(0, 1, SIZE_BYTE, 0, 32'h11, 32'hABCDEFF0);
        issue(1, 0, SIZE_WORD, 0, 32'h10, 32'd0);
        issue(1, 0, SIZE_BYTE, 0, 32'h11, 32'd0);
        issue(1, 0, SIZE_BYTE, 1, 32'h11, 32'd0);
        issue(0, 1, SIZE_HALF, 0, 32'h02, 32'h55558001);
        issue(1, 0, SIZE_HALF, 0, 32'h02, 32'd0);
        issue(1, 0, SIZE_HALF, 1, 32'h02, 32'd0);

        // Faulting requests, then read back to see nothing changed
        issue(1, 0, SIZE_WORD, 0, 32'h12, 32'd0);
        issue(0, 1, SIZE_HALF, 0, 32'h13, 32'hFFFF);
        issue(1, 0, SIZE_ILLEGAL, 0, 32'h10, 32'd0);
        issue(1, 1, SIZE_WORD, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 1, SIZE_WORD, 0, 32'(MEM_BYTES), 32'hCAFEF00D);
        issue(1, 0, SIZE_WORD, 0, 32'(MEM_BYTES), 32'd0);
        issue(0, 1, SIZE_BYTE, 0, 32'h8000_0010, 32'h77);
        issue(0, 0, SIZE_WORD, 0, 32'h10, 32'h99999999);
        issue(1, 0, SIZE_WORD, 0, 32'h10, 32'd0);
        issue(1, 0, SIZE_WORD, 0, 32'h00, 32'd0);
        issue(1, 0, SIZE_WORD, 0, 32'h0C, 32'd0);

        // Back-to-back loads: responses on consecutive cycles, in order
        for (int i = 0; i < 4; i++) issue(0, 1, SIZE_WORD, 0, 32'(4 * i), 32'(i + 1));
        for (int i = 0; i < 4; i++) issue(1, 0, SIZE_WORD, 0, 32'(4 * i), 32'd0);
        idle();
        drain();

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
                continue;
            end
            sel = int'($urandom_range(0, 9));
            rd  = (sel == 1) || (sel >= 6);
            wr  = (sel == 1) || (sel >= 2 && sel <= 5);
            sz  = 2'($urandom_range(0, 3));
            a   = 32'($urandom_range(0, int'(MEM_BYTES) + 7));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SIZE_HALF) a[0] = 1'b0;
                if (sz == SIZE_WORD) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 19) == 0) a[28] = 1'b1;
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        idle();
        drain();

        // Reset with two loads in flight: both dropped, clear restarts
        issue(1, 0, SIZE_WORD, 0, 32'h00, 32'd0);
        issue(1, 0, SIZE_WORD, 0, 32'h04, 32'd0);
        @(negedge Clk);
        ReqValid = 1'b0;
        MemRead  = 1'b0;
        Reset    = 1'b1;
        expQ.delete();
        @(negedge Clk);
        check("midreset_req_ready", 32'(ReqReady), 32'd0);
        check("midreset_resp_valid", 32'(RespValid), 32'd0);
        releaseAndMeasure(lows, resp);
        check("reclear_cycles", 32'(lows), 32'(DEPTH));
        check("reclear_no_resp", 32'(resp), 32'd0);
        clearModel();
        for (int i = 0; i < 16; i += 4) issue(1, 0, SIZE_WORD, 0, 32'(i), 32'd0);
        issue(1, 0, SIZE_WORD, 0, 32'h10, 32'd0);
        idle();
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mips_byte_data_memory.md
# mips_byte_data_memory

Parametrised successor to the single-cycle word data memory. It adds byte-addressed little-endian access (byte, half and word) with sign or zero extension, and a configurable read latency through a valid/ready pipeline. It also flags misaligned and out-of-range accesses, and clears the array in hardware after reset. It sits in the MEM stage of the MIPS datapath, between the ALU address result and the write-back mux.

## Interface
- ADDR_WIDTH, 14, byte-address bits decoded; depth = 2^(ADDR_WIDTH-2) words (default 4096)
- READ_LATENCY, 1, cycles from accept edge to response, legal 1..4
- CLEAR_ON_RESET, 1, 1 = zero the array after reset, 0 = keep contents

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  asynchronous, active-high
- ReqValid  in  1  request present
- ReqReady  out  1  block can accept; a request is accepted on an edge where ReqValid & ReqReady
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0
- Address  in  32  byte address
- WriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- RespValid  out  1  one-cycle pulse per accepted load or store
- ReadData  out  32  extended load data; 0 for stores and faults
- Fault  out  1  valid with RespValid: misaligned, out of range, illegal Size, or MemRead & MemWrite

## Operation
- FSM states are CLEAR and READY.
- Reset: enter CLEAR if CLEAR_ON_RESET, else READY. Clear address = 0.
- CLEAR: write word 0 at the clear address each cycle and increment it. After the last word (depth-1), go to READY. ReqReady = 0 throughout.
- READY: ReqReady = 1.
- Accepted request with neither MemRead nor MemWrite: no effect, no response.
- Fault conditions, checked at accept:
  - Size=01 with Address[0]=1
  - Size=10 with Address[1:0]≠0
  - Size=11
  - Address ≥ 2^ADDR_WIDTH
  - MemRead & MemWrite
- Faulting request: no array write. Response carries Fault=1, ReadData=0.
- Store: read-free byte-lane write to word Address[ADDR_WIDTH-1:2]. Lanes are selected by Address[1:0] and Size; unselected bytes are unchanged.
- Load: synchronous word read at the accept edge. Extract lane by Address[1:0]/Size, extend per Unsigned, then delay through READ_LATENCY-1 further register stages.
- Store then load to the same word on the next accept returns the new data; no forwarding is needed since the array is written at the accept edge.
- Pipeline stages carry {valid, fault, data}. One request may be accepted per cycle with no back-pressure from the response side.

## Timing
- Reset values: ReqReady=0 (CLEAR) or 1 (no clear), RespValid=0, ReadData=0, Fault=0. All pipeline valids are 0.
- Reset asserted mid-operation: in-flight responses are dropped, and no RespValid occurs for them. Partially cleared or stored contents are indeterminate only if CLEAR_ON_RESET=0; otherwise clearing restarts at word 0.
- CLEAR lasts exactly depth cycles after Reset deasserts. ReqReady rises in the cycle after the last clear write (default: cycle 4096 counting from 0).
- Latency: request accepted at edge k gives RespValid high from edge k+READ_LATENCY−1 to edge k+READ_LATENCY, i.e. registered and visible in the cycle after edge k for L=1.
- Back-to-back accepts give back-to-back RespValid pulses in order.
- ReqValid while ReqReady=0 is ignored and does not stall state.

## Structure
- Package mips_mem_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - the fault predicate as a function (addr, size, rd, wr, ADDR_WIDTH)
  - the FSM state enum {CLEAR, READY}
- Sub-module mips_mem_lane_align (combinational) provides:
  - store: byte-enable mask and lane-shifted data from Address[1:0]/Size/WriteData
  - load: lane extract plus sign/zero extension
- Top holds the array, clear counter/FSM, accept logic and latency pipeline.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=6 → ReqReady low exactly 16 cycles, then 1. Word loads at 0x0..0x3C all return 0.
- Store word 0x11223344 at 0x10, then byte loads at 0x10..0x13 → 0x44, 0x33, 0x22, 0x11.
  - Half load at 0x12 signed → 0x00001122.
  - Store byte 0xF0 at 0x11, then word load at 0x10 → 0x1122F044.
  - Signed byte load at 0x11 → 0xFFFFFFF0; unsigned → 0x000000F0.
- Word load at 0x12, half store at 0x13, Size=11, MemRead&MemWrite, and an address at 2^ADDR_WIDTH → each gives RespValid with Fault=1, ReadData=0, and memory unchanged.
- READ_LATENCY=3, four back-to-back loads at 0x0,0x4,0x8,0xC holding 1,2,3,4 → RespValid on 4 consecutive cycles starting 3 cycles after the first accept, data 1,2,3,4 in order.
- Reset pulsed with two loads in flight → no RespValid after reset. Clear restarts and ReqReady is low again for the full depth.
